i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

I2C responder (slave) for the camera-configuration bus: the target-side counterpart of the I2C write controller. It oversamples SCL/SDA on clk2 and decodes START/STOP, the device address and an 8-bit register pointer. Writes arrive as 16-bit words that are strobed out to a register file; reads fetch 16-bit words from that file. Used as a sensor model in simulation and as an on-FPGA register target for bring-up.

## Interface
- DEV_ADDR, 7'h5D, 7-bit device address (write byte 0xBA, read byte 0xBB)
- SYNC_STAGES, 2, synchronizer depth on scl/sda (≥2)
- clk2  in  1  system clock; must be ≥ 8× SCL frequency
- reset  in  1  asynchronous, active-low
- scl  in  1  bus clock (input only, no clock stretching)
- sda  in  1  bus data as seen on the pin
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  8  register index for wr_en
- wr_data  out  16  write word, {high byte, low byte}
- rd_addr  out  8  register index presented for reads
- rd_data  in  16  read word, combinational from the register file for rd_addr
- busy  out  1  1 between an accepted START and the next STOP

## Operation
- scl/sda pass through SYNC_STAGES flops, then one history flop. Events:
  - rise/fall: scl edges.
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
- Bits are sampled on the scl rise, MSB first. sda_oe changes only on the scl fall, or on START/STOP.
- States: IDLE, ADDR, ACK_A, REG, ACK_R, WR_HI, ACK_WH, WR_LO, ACK_WL, RD_HI, MACK_H, RD_LO, MACK_L.
- START from any state: bit counter = 0, sda_oe = 0, busy = 1, go to ADDR. This covers repeated START.
- STOP from any state: go to IDLE, sda_oe = 0, busy = 0. The pointer is kept.
- ADDR: shift 8 bits, then check the upper 7 against DEV_ADDR.
  - Match: ACK_A.
  - Mismatch: IDLE (no ACK, ignore the bus until the next START).
  - The R/W bit is latched.
- ACK_A: pull low for the 9th bit. Next state: W → REG; R → RD_HI.
- REG: 8 bits load the pointer, then ACK_R, then WR_HI.
- WR_HI / WR_LO: each byte is ACKed via ACK_WH / ACK_WL.
  - On the 8th-bit rise of WR_LO: wr_en = 1 for one cycle, with wr_addr = pointer and wr_data = {hi, lo}. The pointer then increments (8-bit wrap, 0xFF→0x00).
  - After ACK_WL, go to WR_HI for the next word.
- RD_HI: on entry, latch rd_data for the current pointer (rd_addr = pointer). Drive bits [15:8] with sda_oe = ~bit, then release the bus for MACK_H.
  - Master ACK (sda = 0): go to RD_LO.
  - NACK: go to IDLE.
- RD_LO: drive bits [7:0], then MACK_L. The pointer increments after the 8th bit.
  - ACK: RD_HI with a fresh latch.
  - NACK: IDLE.
- A read with no preceding REG phase uses the current pointer.

## Timing
- Reset values: sda_oe = 0, wr_en = 0, wr_addr = 0, wr_data = 0, rd_addr = 0, busy = 0, pointer = 0, state IDLE.
- Reset mid-transfer aborts immediately. No write strobe is issued for a partial word.
- Detection latency is SYNC_STAGES+1 clk2 cycles from a pin change to the event.
- sda_oe updates exactly one clk2 cycle after the detected scl fall.
- wr_en: one clk2 cycle after the detected 8th rise of WR_LO.
- A STOP or START in the middle of a byte discards that byte. No wr_en is issued for a partial word.
- START and scl fall are never detected in the same cycle; if both, START wins.

## Structure
- Shared package i2c_pkg holds:
  - the state enumeration;
  - the device write byte constant 8'hBA, also used by the I2C write controller;
  - a bit-count width constant of 4.
- Sub-module i2c_bus_sync (synchronizer plus START/STOP/rise/fall detector), instantiated once. The FSM and data path form the top.

## Test plan
- Write 0xBA, 0x05, 0x12, 0x34 then STOP → 3 ACKs plus a final ACK; one wr_en with wr_addr = 0x05, wr_data = 0x1234.
- Address 0xA0 → no ACK (sda_oe stays 0 for the whole transfer); no wr_en; busy drops at STOP.
- Burst: 0xBA, 0xFF, then words 0xAAAA and 0x5555 → wr_en at addresses 0xFF then 0x00 (wrap).
- Write 0xBA, 0x10, repeated START, 0xBB, with rd_data(0x10) = 0xBEEF; master ACK then NACK → bus bytes 0xBE, 0xEF; rd_addr = 0x11 afterwards; IDLE.
- STOP after the 4 data bits of WR_LO → no wr_en; state IDLE; the next full transfer works normally.
- Assert reset while driving ACK_R → sda_oe = 0 within one cycle; all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, device write byte and
// bit-counter width, common to the responder and the write controller.
package i2c_pkg;

    // 7-bit address 0x5D shifted left with R/W = 0
    localparam logic [7:0] DEV_WR_BYTE = 8'hBA;

    // Wide enough to count 0..8 bit positions within a byte
    localparam int BIT_CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        REG,
        ACK_R,
        WR_HI,
        ACK_WH,
        WR_LO,
        ACK_WL,
        RD_HI,
        MACK_H,
        RD_LO,
        MACK_L
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into clk2 and decodes scl edges plus START/STOP.
// Events are combinational from the last sync stage and one history flop.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk2,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_pipe[SYNC_STAGES-1];
    assign sda_s = sda_pipe[SYNC_STAGES-1];

    // Sync chains and history flops; reset to an idle (released) bus
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
            scl_hist <= scl_s;
            sda_hist <= sda_s;
        end
    end

    // START/STOP require scl high on both sides of the sda transition
    assign scl_rise  =  scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s &  scl_hist;
    assign start_det =  scl_s &  scl_hist & sda_hist & ~sda_s;
    assign stop_det  =  scl_s &  scl_hist & ~sda_hist & sda_s;
    assign sda_bit   =  sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C register responder: device address, 8-bit register pointer, 16-bit
// word writes strobed to a register file and 16-bit word reads from it.
//
// state  | meaning
// IDLE   | ignoring the bus until the next START
// ADDR   | shifting in the address byte
// ACK_A  | acknowledging our address
// REG    | shifting in the register pointer
// ACK_R  | acknowledging the pointer
// WR_HI  | shifting in the high byte of a write word
// ACK_WH | acknowledging the high byte
// WR_LO  | shifting in the low byte; strobes the write on its 8th bit
// ACK_WL | acknowledging the low byte
// RD_HI  | driving bits [15:8] of the latched read word
// MACK_H | releasing the bus for the master ACK/NACK
// RD_LO  | driving bits [7:0]; pointer advances on its 8th bit
// MACK_L | releasing the bus for the master ACK/NACK
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_WR_BYTE[7:1],
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk2,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [7:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        busy
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(7);
    localparam logic [BIT_CNT_W-1:0] BYTE_DONE = BIT_CNT_W'(8);

    logic                 scl_rise;
    logic                 scl_fall;
    logic                 start_det;
    logic                 stop_det;
    logic                 sda_bit;

    i2c_state_t           state;
    logic [BIT_CNT_W-1:0] cnt;
    logic [6:0]           shreg;
    logic [7:0]           byte_in;
    logic [7:0]           ptr;
    logic [7:0]           hi_byte;
    logic [15:0]          rd_word;
    logic                 rw;
    logic                 ack_on;
    logic                 mack;
    logic [3:0]           hi_idx;
    logic [2:0]           lo_idx;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk2      (clk2),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    // Byte as it stands after the bit being sampled on this rise
    assign byte_in = {shreg, sda_bit};
    assign hi_idx  = 4'd15 - cnt;
    assign lo_idx  = 3'd7 - cnt[2:0];
    assign rd_addr = ptr;

    // Protocol FSM with registered bus drive and register-file strobes
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            ptr     <= '0;
            hi_byte <= '0;
            rd_word <= '0;
            rw      <= 1'b0;
            ack_on  <= 1'b0;
            mack    <= 1'b0;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state  <= ADDR;
                cnt    <= '0;
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;

                    ADDR, REG, WR_HI, WR_LO: begin
                        if (scl_rise) begin
                            shreg <= byte_in[6:0];
                            cnt   <= cnt + 1'b1;
                            if (cnt == LAST_BIT) begin
                                cnt    <= '0;
                                ack_on <= 1'b0;
                                case (state)
                                    ADDR: begin
                                        if (byte_in[7:1] == DEV_ADDR) begin
                                            rw    <= byte_in[0];
                                            state <= ACK_A;
                                        end else begin
                                            // Not ours: stay quiet, busy holds until STOP
                                            state <= IDLE;
                                        end
                                    end
                                    REG: begin
                                        ptr   <= byte_in;
                                        state <= ACK_R;
                                    end
                                    WR_HI: begin
                                        hi_byte <= byte_in;
                                        state   <= ACK_WH;
                                    end
                                    default: begin
                                        wr_en   <= 1'b1;
                                        wr_addr <= ptr;
                                        wr_data <= {hi_byte, byte_in};
                                        ptr     <= ptr + 8'd1;
                                        state   <= ACK_WL;
                                    end
                                endcase
                            end
                        end
                    end

                    // First fall pulls SDA low, the fall after the 9th rise releases it
                    ACK_A, ACK_R, ACK_WH, ACK_WL: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                ack_on <= 1'b0;
                                cnt    <= '0;
                                case (state)
                                    ACK_A: begin
                                        if (rw) begin
                                            rd_word <= rd_data;
                                            sda_oe  <= ~rd_data[15];
                                            state   <= RD_HI;
                                        end else begin
                                            sda_oe <= 1'b0;
                                            state  <= REG;
                                        end
                                    end
                                    ACK_R: begin
                                        sda_oe <= 1'b0;
                                        state  <= WR_HI;
                                    end
                                    ACK_WH: begin
                                        sda_oe <= 1'b0;
                                        state  <= WR_LO;
                                    end
                                    default: begin
                                        sda_oe <= 1'b0;
                                        state  <= WR_HI;
                                    end
                                endcase
                            end
                        end
                    end

                    // Bit 15 was placed on entry; each later fall places the next bit
                    RD_HI: begin
                        if (scl_rise) begin
                            cnt <= cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (cnt == BYTE_DONE) begin
                                sda_oe <= 1'b0;
                                mack   <= 1'b0;
                                state  <= MACK_H;
                            end else begin
                                sda_oe <= ~rd_word[hi_idx];
                            end
                        end
                    end

                    RD_LO: begin
                        if (scl_rise) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST_BIT) begin
                                ptr <= ptr + 8'd1;
                            end
                        end else if (scl_fall) begin
                            if (cnt == BYTE_DONE) begin
                                sda_oe <= 1'b0;
                                mack   <= 1'b0;
                                state  <= MACK_L;
                            end else begin
                                sda_oe <= ~rd_word[{1'b0, lo_idx}];
                            end
                        end
                    end

                    MACK_H, MACK_L: begin
                        if (scl_rise) begin
                            mack <= ~sda_bit;
                        end else if (scl_fall) begin
                            cnt <= '0;
                            if (!mack) begin
                                sda_oe <= 1'b0;
                                state  <= IDLE;
                            end else if (state == MACK_H) begin
                                sda_oe <= ~rd_word[7];
                                state  <= RD_LO;
                            end else begin
                                // Pointer already advanced, so this fetches the next word
                                rd_word <= rd_data;
                                sda_oe  <= ~rd_data[15];
                                state   <= RD_HI;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged bus master plus a small
// register-file model, with per-scenario tasks checking against fixed values.
module tb_i2c_slave_regs;

    localparam int Q = 4;

    logic        clk2;
    logic        reset;
    logic        m_scl;
    logic        m_sda;
    logic        sda_pin;
    logic        sda_oe;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic        oe_seen;

    i2c_slave_regs dut (
        .clk2    (clk2),
        .reset   (reset),
        .scl     (m_scl),
        .sda     (sda_pin),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    assign sda_pin = m_sda & ~sda_oe;
    assign rd_data = (rd_addr == 8'h10) ? 16'hBEEF : {rd_addr, ~rd_addr};

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    always @(negedge clk2) begin
        if (wr_en) begin
            wr_addr_q.push_back(wr_addr);
            wr_data_q.push_back(wr_data);
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk2);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        oe_seen = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic clk_bit(input logic v, output logic sampled);
        m_sda = v;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        sampled = sda_pin;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(~give_ack, s);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(3);
        checks++;
        if ({sda_oe, wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got oe/wr_en/busy=%b want 000", {sda_oe, wr_en, busy});
        end
        checks++;
        if ({wr_addr, wr_data, rd_addr} !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got %h/%h/%h want 0/0/0", wr_addr, wr_data, rd_addr);
        end
        reset = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        clear_log();
        bus_start();
        send_byte(8'hBA, a0);
        send_byte(8'h05, a1);
        send_byte(8'h12, a2);
        send_byte(8'h34, a3);
        checks++;
        if ({a0, a1, a2, a3} !== 4'b1111) begin
            errors++;
            $display("FAIL write_acks got %b want 1111", {a0, a1, a2, a3});
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy got %b want 1", busy);
        end
        bus_stop();
        wait_clk(Q);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_stop got %b want 0", busy);
        end
        checks++;
        if (wr_addr_q.size() != 1) begin
            errors++;
            $display("FAIL write_count got %0d want 1", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 8'h05 || wr_data_q[0] !== 16'h1234) begin
                errors++;
                $display("FAIL write_word got %h:%h want 05:1234", wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    task automatic test_nack_addr();
        logic a0, a1, a2;
        clear_log();
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h05, a1);
        send_byte(8'h12, a2);
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++;
            $display("FAIL nack_acks got %b want 000", {a0, a1, a2});
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nack_busy got %b want 1", busy);
        end
        bus_stop();
        wait_clk(Q);
        checks++;
        if (busy !== 1'b0 || oe_seen !== 1'b0 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL nack_after got busy=%b oe_seen=%b writes=%0d want 0 0 0",
                     busy, oe_seen, wr_addr_q.size());
        end
    endtask

    task automatic test_burst_wrap();
        logic [5:0] acks;
        clear_log();
        bus_start();
        send_byte(8'hBA, acks[5]);
        send_byte(8'hFF, acks[4]);
        send_byte(8'hAA, acks[3]);
        send_byte(8'hAA, acks[2]);
        send_byte(8'h55, acks[1]);
        send_byte(8'h55, acks[0]);
        bus_stop();
        wait_clk(Q);
        checks++;
        if (acks !== 6'b111111) begin
            errors++;
            $display("FAIL burst_acks got %b want 111111", acks);
        end
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++;
            $display("FAIL burst_count got %0d want 2", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 8'hFF || wr_data_q[0] !== 16'hAAAA) begin
                errors++;
                $display("FAIL burst_w0 got %h:%h want ff:aaaa", wr_addr_q[0], wr_data_q[0]);
            end
            checks++;
            if (wr_addr_q[1] !== 8'h00 || wr_data_q[1] !== 16'h5555) begin
                errors++;
                $display("FAIL burst_w1 got %h:%h want 00:5555", wr_addr_q[1], wr_data_q[1]);
            end
        end
        checks++;
        if (rd_addr !== 8'h01) begin
            errors++;
            $display("FAIL burst_ptr got %h want 01", rd_addr);
        end
    endtask

    task automatic test_read_rstart();
        logic a0, a1, a2;
        logic [7:0] b_hi, b_lo;
        clear_log();
        bus_start();
        send_byte(8'hBA, a0);
        send_byte(8'h10, a1);
        bus_start();
        send_byte(8'hBB, a2);
        read_byte(1'b1, b_hi);
        read_byte(1'b0, b_lo);
        bus_stop();
        wait_clk(Q);
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin
            errors++;
            $display("FAIL read_acks got %b want 111", {a0, a1, a2});
        end
        checks++;
        if (b_hi !== 8'hBE || b_lo !== 8'hEF) begin
            errors++;
            $display("FAIL read_bytes got %h %h want be ef", b_hi, b_lo);
        end
        checks++;
        if (rd_addr !== 8'h11) begin
            errors++;
            $display("FAIL read_ptr got %h want 11", rd_addr);
        end
        checks++;
        if (busy !== 1'b0 || sda_oe !== 1'b0 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL read_after got busy=%b oe=%b writes=%0d want 0 0 0",
                     busy, sda_oe, wr_addr_q.size());
        end
    endtask

    task automatic test_stop_partial();
        logic a0, a1, a2, s;
        logic [3:0] acks;
        logic [7:0] lo;
        clear_log();
        lo = 8'h22;
        bus_start();
        send_byte(8'hBA, a0);
        send_byte(8'h20, a1);
        send_byte(8'h11, a2);
        for (int i = 7; i >= 4; i--) clk_bit(lo[i], s);
        bus_stop();
        wait_clk(Q);
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL partial_stop got writes=%0d busy=%b oe=%b want 0 0 0",
                     wr_addr_q.size(), busy, sda_oe);
        end
        bus_start();
        send_byte(8'hBA, acks[3]);
        send_byte(8'h30, acks[2]);
        send_byte(8'hCA, acks[1]);
        send_byte(8'hFE, acks[0]);
        bus_stop();
        wait_clk(Q);
        checks++;
        if (acks !== 4'b1111) begin
            errors++;
            $display("FAIL partial_next_acks got %b want 1111", acks);
        end
        checks++;
        if (wr_addr_q.size() != 1) begin
            errors++;
            $display("FAIL partial_next_count got %0d want 1", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 8'h30 || wr_data_q[0] !== 16'hCAFE) begin
                errors++;
                $display("FAIL partial_next_word got %h:%h want 30:cafe", wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        logic a0, s;
        logic [7:0] p;
        p = 8'h07;
        bus_start();
        send_byte(8'hBA, a0);
        for (int i = 7; i >= 0; i--) clk_bit(p[i], s);
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("FAIL midack_drive got oe=%b want 1", sda_oe);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({sda_oe, wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midack_reset_ctrl got oe/wr_en/busy=%b want 000", {sda_oe, wr_en, busy});
        end
        checks++;
        if ({wr_addr, wr_data, rd_addr} !== 32'h0) begin
            errors++;
            $display("FAIL midack_reset_regs got %h/%h/%h want 0/0/0", wr_addr, wr_data, rd_addr);
        end
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clk(Q);
        reset = 1'b1;
        wait_clk(2 * Q);
        checks++;
        if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL midack_release got busy=%b oe=%b want 0 0", busy, sda_oe);
        end
    endtask

    initial begin
        m_scl = 1'b1;
        m_sda = 1'b1;
        oe_seen = 1'b0;
        test_reset();
        test_write();
        test_nack_addr();
        test_burst_wrap();
        test_read_rstart();
        test_stop_partial();
        test_reset_mid_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
